// File: rtl/scmp_uart_pkg.sv
// Shared types and constants for the SCMP serial-out receiver.
package scmp_uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 434;
  localparam int DATA_W               = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/scmp_rx_fifo.sv
// Receive byte buffer: 2**AW-entry ring with an extra pointer bit for full/empty,
// or a single holding register when AW is 0.
module scmp_rx_fifo
  import scmp_uart_pkg::*;
#(
  parameter int AW = 2
) (
  input  logic              clk_50m,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full
);

  logic rd_en;
  logic wr_en;

  // A pop frees the slot the same cycle, so a push into a full buffer succeeds alongside it.
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);

  generate
    if (AW == 0) begin : g_reg
      logic [DATA_W-1:0] hold;
      logic              occ;

      always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
          hold <= '0;
          occ  <= 1'b0;
        end else begin
          if (wr_en) begin
            hold <= din;
            occ  <= 1'b1;
          end else if (rd_en) begin
            occ <= 1'b0;
          end
        end
      end

      assign dout  = hold;
      assign empty = ~occ;
      assign full  = occ;
    end else begin : g_ring
      logic [DATA_W-1:0] mem [2**AW];
      logic [AW:0]       wr_ptr;
      logic [AW:0]       rd_ptr;

      always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          for (int i = 0; i < 2**AW; i++) begin
            mem[i] <= '0;
          end
        end else begin
          if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= din;
            wr_ptr              <= wr_ptr + 1'b1;
          end
          if (rd_en) begin
            rd_ptr <= rd_ptr + 1'b1;
          end
        end
      end

      assign dout  = mem[rd_ptr[AW-1:0]];
      assign empty = (wr_ptr == rd_ptr);
      assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    end
  endgenerate

endmodule

// File: rtl/scmp_sout_rx.sv
// 8N1 receiver for the SCMP CPU serial output, with sticky error flags and a receive buffer.
// Define SCMP_RX_FIFO_EN for a 2**FIFO_AW-entry FIFO; otherwise a single holding register.
module scmp_sout_rx
  import scmp_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_AW      = 2
) (
  input  logic              clk_50m,
  input  logic              rst_n,
  input  logic              rx,
  input  logic              rd,
  input  logic              clr_err,
  output logic [DATA_W-1:0] data_o,
  output logic              valid,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

`ifdef SCMP_RX_FIFO_EN
  localparam int BUF_AW = FIFO_AW;
`else
  localparam int BUF_AW = 0;
`endif

  localparam logic [15:0] FULL_BIT = 16'(CLKS_PER_BIT);
  localparam logic [15:0] HALF_BIT = 16'(CLKS_PER_BIT / 2);

  rx_state_t         state;
  rx_state_t         state_nxt;
  logic              rx_meta;
  logic              rx_sync;
  logic              rx_prev;
  logic [15:0]       cnt;
  logic [2:0]        bit_idx;
  logic [DATA_W-1:0] shreg;
  logic              fall;
  logic              expire;
  logic              push;
  logic              frame_set;
  logic              overrun_set;
  logic              pop;
  logic              fifo_empty;
  logic              fifo_full;

  // Flops reset to the idle-high line level so release from reset never looks like a start bit.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign fall   = rx_prev & ~rx_sync;
  assign expire = (cnt == 16'd1);

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fall) state_nxt = START;
      START:   if (expire) state_nxt = rx_sync ? IDLE : DATA;
      DATA:    if (expire && (bit_idx == 3'd7)) state_nxt = STOP;
      STOP:    if (expire) state_nxt = rx_sync ? IDLE : BREAK;
      BREAK:   if (rx_sync) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    push      = (state == STOP) & expire & rx_sync;
    frame_set = (state == STOP) & expire & ~rx_sync;
  end

  // Half-bit load on the start edge puts every later sample near mid-bit.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if (state == IDLE) begin
        bit_idx <= '0;
        if (fall) begin
          cnt <= HALF_BIT;
        end
      end else if (state != BREAK) begin
        cnt <= expire ? FULL_BIT : cnt - 16'd1;
      end
      if ((state == DATA) && expire) begin
        shreg   <= {rx_sync, shreg[DATA_W-1:1]};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  assign pop         = rd & ~fifo_empty;
  assign overrun_set = push & fifo_full & ~pop;

  // A set event in the same cycle as clr_err wins.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (frame_set) begin
        frame_err <= 1'b1;
      end else if (clr_err) begin
        frame_err <= 1'b0;
      end
      if (overrun_set) begin
        overrun <= 1'b1;
      end else if (clr_err) begin
        overrun <= 1'b0;
      end
    end
  end

  scmp_rx_fifo #(
    .AW (BUF_AW)
  ) u_fifo (
    .clk_50m (clk_50m),
    .rst_n   (rst_n),
    .push    (push),
    .din     (shreg),
    .pop     (pop),
    .dout    (data_o),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign valid = ~fifo_empty;

endmodule

// File: tb/tb_scmp_sout_rx.sv
// Directed bench for scmp_sout_rx at 16 clocks per bit; buffer depth follows SCMP_RX_FIFO_EN.
module tb_scmp_sout_rx;

  localparam int CPB = 16;
`ifdef SCMP_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic       clk_50m = 1'b0;
  logic       rst_n   = 1'b0;
  logic       rx      = 1'b1;
  logic       rd      = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] data_o;
  logic       valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_assert = 0;
  int n_fail   = 0;

  always #10 clk_50m = ~clk_50m;

  scmp_sout_rx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_AW      (2)
  ) dut (
    .clk_50m   (clk_50m),
    .rst_n     (rst_n),
    .rx        (rx),
    .rd        (rd),
    .clr_err   (clr_err),
    .data_o    (data_o),
    .valid     (valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk_50m);
      #1;
    end
  endtask

  // Sends one frame starting 1 time unit after a rising edge; stop sample lands on the 11th edge of the stop bit.
  task automatic applyStimulus(input logic [7:0] b, input logic stop_val,
                               input bit pop_at_stop, input bit check_edge);
    logic [9:0] frame;
    frame = {stop_val, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = frame[i];
      for (int c = 1; c <= CPB; c++) begin
        @(posedge clk_50m);
        #1;
        if (i == 9) begin
          if (c == 10 && pop_at_stop) rd = 1'b1;
          if (c == 11) rd = 1'b0;
          if (check_edge && c == 10) checkOutput("valid_before_stop", valid, 8'd0);
          if (check_edge && c == 11) checkOutput("valid_after_stop", valid, 8'd1);
        end
      end
    end
  endtask

  task automatic popByte(input logic [7:0] exp);
    checkOutput("pop_valid", valid, 8'd1);
    checkOutput("pop_data", data_o, exp);
    rd = 1'b1;
    @(posedge clk_50m);
    #1;
    rd = 1'b0;
  endtask

  initial begin
    $display("[TB] start");
    rst_n = 1'b0;
    waitCycles(3);
    checkOutput("rst_valid", valid, 8'd0);
    checkOutput("rst_data", data_o, 8'h00);
    checkOutput("rst_frame_err", frame_err, 8'd0);
    checkOutput("rst_overrun", overrun, 8'd0);
    checkOutput("rst_busy", busy, 8'd0);
    rst_n = 1'b1;
    waitCycles(2);

    // Clean frame, valid edge one cycle after the stop sample
    applyStimulus(8'hA5, 1'b1, 1'b0, 1'b1);
    checkOutput("a5_data", data_o, 8'hA5);
    checkOutput("a5_frame_err", frame_err, 8'd0);
    checkOutput("a5_busy", busy, 8'd0);
    popByte(8'hA5);
    checkOutput("a5_empty", valid, 8'd0);

    // Short low glitch is rejected at the start-bit check
    rx = 1'b0;
    waitCycles(5);
    rx = 1'b1;
    checkOutput("glitch_busy", busy, 8'd1);
    waitCycles(8);
    checkOutput("glitch_idle", busy, 8'd0);
    checkOutput("glitch_valid", valid, 8'd0);
    checkOutput("glitch_frame_err", frame_err, 8'd0);
    waitCycles(4);

    // Low stop bit: frame error, held in BREAK until the line returns high
    applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0);
    waitCycles(40);
    checkOutput("brk_frame_err", frame_err, 8'd1);
    checkOutput("brk_busy", busy, 8'd1);
    checkOutput("brk_valid", valid, 8'd0);
    rx = 1'b1;
    waitCycles(1);
    checkOutput("brk_hold", busy, 8'd1);
    waitCycles(3);
    checkOutput("brk_exit", busy, 8'd0);
    applyStimulus(8'h11, 1'b1, 1'b0, 1'b0);
    checkOutput("after_brk_sticky", frame_err, 8'd1);
    popByte(8'h11);

    clr_err = 1'b1;
    waitCycles(1);
    clr_err = 1'b0;
    checkOutput("clr_frame_err", frame_err, 8'd0);

    // Five bytes without reading: extras beyond the depth are dropped
    for (int i = 0; i < 5; i++) begin
      applyStimulus(8'(i + 1), 1'b1, 1'b0, 1'b0);
      checkOutput("fill_overrun", overrun, 8'((i + 1) > DEPTH));
      checkOutput("fill_valid", valid, 8'd1);
    end
    for (int i = 0; i < DEPTH; i++) begin
      popByte(8'(i + 1));
    end
    checkOutput("drain_valid", valid, 8'd0);
    checkOutput("drain_overrun_sticky", overrun, 8'd1);
    clr_err = 1'b1;
    waitCycles(1);
    clr_err = 1'b0;
    checkOutput("clr_overrun", overrun, 8'd0);

    // Full buffer with a pop in the push cycle of 8'h77
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(8'(8'h10 + i), 1'b1, 1'b0, 1'b0);
    end
    applyStimulus(8'h77, 1'b1, 1'b1, 1'b0);
    checkOutput("full_pop_overrun", overrun, 8'd0);
    checkOutput("full_pop_valid", valid, 8'd1);
    for (int i = 1; i < DEPTH; i++) begin
      popByte(8'(8'h10 + i));
    end
    popByte(8'h77);
    checkOutput("full_pop_empty", valid, 8'd0);

    // rd while empty in the push cycle is ignored; the byte is kept
    applyStimulus(8'h5A, 1'b1, 1'b1, 1'b1);
    checkOutput("empty_rd_data", data_o, 8'h5A);

    // Reset pulsed during data bit 4 of 8'hFF
    rx = 1'b0;
    waitCycles(CPB);
    rx = 1'b1;
    waitCycles(70);
    checkOutput("mid_busy", busy, 8'd1);
    rst_n = 1'b0;
    waitCycles(2);
    checkOutput("mid_rst_valid", valid, 8'd0);
    checkOutput("mid_rst_data", data_o, 8'h00);
    checkOutput("mid_rst_busy", busy, 8'd0);
    rst_n = 1'b1;
    waitCycles(CPB * 10);
    checkOutput("post_rst_busy", busy, 8'd0);
    checkOutput("post_rst_valid", valid, 8'd0);
    checkOutput("post_rst_frame_err", frame_err, 8'd0);
    checkOutput("post_rst_overrun", overrun, 8'd0);
    applyStimulus(8'h42, 1'b1, 1'b0, 1'b1);
    popByte(8'h42);
    checkOutput("final_empty", valid, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
